// File: rtl/ram_loader.sv
// Boot-time program loader: streams bytes into the CPU RAM, verifies a trailing
// checksum, then releases the CPU from clear on a match or flags an error.
module ram_loader #(
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned RELEASE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] load_len,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  output logic                  cpu_clear,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned REM_W = ADDR_WIDTH + 1;
  localparam int unsigned REL_W = 4;
  localparam logic [REM_W-1:0] FULL_LEN = REM_W'(2 ** ADDR_WIDTH);
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHECK, S_RELEASE, S_RUN, S_ERROR
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] count;
  logic [REM_W-1:0]      remaining;
  logic [DATA_WIDTH-1:0] acc;
  logic [REL_W-1:0]      rel_cnt;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] sum_next;

  assign xfer     = in_valid & in_ready;
  assign sum_next = acc + in_data;

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= S_IDLE;
      cpu_clear <= 1'b1;
      in_ready  <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      count     <= '0;
      remaining <= '0;
      acc       <= '0;
      rel_cnt   <= '0;
    end else begin
      ram_we <= 1'b0;
      case (state)
        // A start from IDLE or ERROR always begins a fresh load at address 0
        S_IDLE, S_ERROR: begin
          if (start) begin
            remaining <= (load_len == '0) ? FULL_LEN : REM_W'(load_len);
            count     <= '0;
            acc       <= '0;
            state     <= S_LOAD;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            error     <= 1'b0;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            ram_we    <= 1'b1;
            ram_addr  <= count;
            ram_data  <= in_data;
            count     <= count + 1'b1;
            acc       <= sum_next;
            remaining <= remaining - 1'b1;
            if (remaining == REM_W'(1)) state <= S_CHECK;
          end
        end
        // Checksum byte: the running sum including it must wrap to zero
        S_CHECK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (sum_next == '0) begin
              state   <= S_RELEASE;
              rel_cnt <= '0;
            end else begin
              state <= S_ERROR;
              busy  <= 1'b0;
              error <= 1'b1;
            end
          end
        end
        S_RELEASE: begin
          if (rel_cnt == REL_LAST) begin
            state     <= S_RUN;
            busy      <= 1'b0;
            done      <= 1'b1;
            cpu_clear <= 1'b0;
          end else begin
            rel_cnt <= rel_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Randomized self-checking bench for ram_loader against a transaction-level
// model of the loader's phases, plus directed cases with literal expectations.
module tb_ram_loader;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int RC = 2;
  localparam int DEPTH = 16;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_CHK  = 2;
  localparam int P_REL  = 3;
  localparam int P_RUN  = 4;
  localparam int P_ERR  = 5;

  logic          clk = 1'b0;
  logic          clear, start, in_valid;
  logic [AW-1:0] load_len;
  logic [DW-1:0] in_data;
  logic          in_ready, ram_we, cpu_clear, busy, done, error;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // model state
  int m_ph = P_IDLE, m_left = 0, m_sum = 0, m_next = 0, m_wait = 0;
  int m_we = 0, m_addr = 0, m_data = 0;
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] tb_mem [DEPTH];
  int we_count = 0;

  always #5 clk = ~clk;

  ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RELEASE_CYCLES(RC)) dut (
    .clk(clk), .clear(clear), .start(start), .load_len(load_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .cpu_clear(cpu_clear), .busy(busy), .done(done), .error(error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what each edge must produce given the sampled inputs
  always @(posedge clk) begin
    if (clear) begin
      m_ph = P_IDLE; m_we = 0; m_addr = 0; m_data = 0;
    end else begin
      m_we = 0;
      case (m_ph)
        P_IDLE, P_ERR: if (start) begin
          m_left = (load_len == 0) ? DEPTH : int'(load_len);
          m_sum = 0; m_next = 0; m_ph = P_LOAD;
        end
        P_LOAD: if (in_valid) begin
          m_we = 1; m_addr = m_next; m_data = int'(in_data);
          model_mem[m_next] = in_data;
          m_next = (m_next + 1) % DEPTH;
          m_sum = (m_sum + int'(in_data)) % 256;
          m_left--;
          if (m_left == 0) m_ph = P_CHK;
        end
        P_CHK: if (in_valid) begin
          m_ph = ((m_sum + int'(in_data)) % 256 == 0) ? P_REL : P_ERR;
          m_wait = RC;
        end
        P_REL: begin
          m_wait--;
          if (m_wait == 0) m_ph = P_RUN;
        end
        default: ;
      endcase
    end
  end

  // Observed RAM image built from the write strobe
  always @(posedge clk) begin
    if (ram_we === 1'b1) begin
      tb_mem[ram_addr] <= ram_data;
      we_count <= we_count + 1;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  32'(in_ready),  32'(m_ph == P_LOAD || m_ph == P_CHK));
      chk("cpu_clear", 32'(cpu_clear), 32'(m_ph != P_RUN));
      chk("busy",      32'(busy),      32'(m_ph == P_LOAD || m_ph == P_CHK || m_ph == P_REL));
      chk("done",      32'(done),      32'(m_ph == P_RUN));
      chk("error",     32'(error),     32'(m_ph == P_ERR));
      chk("ram_we",    32'(ram_we),    32'(m_we));
      chk("ram_addr",  32'(ram_addr),  32'(m_addr));
      chk("ram_data",  32'(ram_data),  32'(m_data));
    end
  end

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic start_load(input int len);
    start = 1'b1; load_len = AW'(len);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d, input int gap, input bit st);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0; in_data = DW'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1; in_data = d; start = st; load_len = AW'($urandom);
    @(negedge clk);
    in_valid = 1'b0; start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int k = 0;
    while (!(done || error) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(done | error), 32'd1);
  endtask

  initial begin
    int w0, k, n, len, sum;
    bit bad;
    logic [DW-1:0] d;

    clear = 1'b1; start = 1'b0; load_len = '0; in_data = '0; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_cpu_clear", 32'(cpu_clear), 1);
    chk("rst_busy", 32'(busy | done | error | ram_we), 0);
    clear = 1'b0;

    // Good load of three bytes, back-to-back
    w0 = we_count;
    start_load(3);
    push(8'h1D, 0, 0);
    chk("t1_we0", 32'(ram_we), 1); chk("t1_addr0", 32'(ram_addr), 0); chk("t1_data0", 32'(ram_data), 32'h1D);
    push(8'h2E, 0, 0);
    chk("t1_we1", 32'(ram_we), 1); chk("t1_addr1", 32'(ram_addr), 1); chk("t1_data1", 32'(ram_data), 32'h2E);
    push(8'h3F, 0, 0);
    chk("t1_we2", 32'(ram_we), 1); chk("t1_addr2", 32'(ram_addr), 2); chk("t1_data2", 32'(ram_data), 32'h3F);
    push(8'h76, 0, 0);
    chk("t1_we_after", 32'(ram_we), 0);
    chk("t1_ready_after", 32'(in_ready), 0);
    k = 1;
    while (cpu_clear && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("t1_release_latency", 32'(k), 3);
    chk("t1_done", 32'(done), 1);
    chk("t1_we_count", 32'(we_count - w0), 3);

    // Bad checksum, then recovery via start from ERROR
    do_clear();
    start_load(3);
    push(8'h1D, 0, 0); push(8'h2E, 0, 0); push(8'h3F, 0, 0); push(8'h77, 0, 0);
    @(negedge clk);
    chk("t2_error", 32'(error), 1);
    chk("t2_cpu_clear", 32'(cpu_clear), 1);
    chk("t2_ready", 32'(in_ready), 0);
    start_load(2);
    chk("t2_error_cleared", 32'(error), 0);
    push(8'h10, 0, 0); push(8'h20, 1, 0); push(8'hD0, 0, 0);
    wait_end("t2_end");
    chk("t2_done", 32'(done), 1);
    chk("t2_error_final", 32'(error), 0);

    // Full-depth load with in_valid toggling
    do_clear();
    w0 = we_count;
    start_load(0);
    for (int i = 0; i < DEPTH; i++) push(DW'(i), 1, 0);
    push(8'h88, 1, 0);
    wait_end("t3_end");
    chk("t3_done", 32'(done), 1);
    chk("t3_we_count", 32'(we_count - w0), 16);
    for (int i = 0; i < DEPTH; i++) chk("t3_mem", 32'(tb_mem[i]), 32'(i));

    // Clear in the middle of a load
    do_clear();
    start_load(4);
    push(8'hA1, 0, 0); push(8'hB2, 0, 0);
    do_clear();
    chk("t4_ready", 32'(in_ready), 0);
    chk("t4_we", 32'(ram_we), 0);
    chk("t4_cpu_clear", 32'(cpu_clear), 1);
    chk("t4_busy", 32'(busy), 0);
    start_load(1);
    push(8'hAA, 0, 0);
    chk("t4_restart_addr", 32'(ram_addr), 0);
    chk("t4_restart_data", 32'(ram_data), 32'hAA);
    push(8'h56, 0, 0);
    wait_end("t4_end");
    chk("t4_done", 32'(done), 1);

    // Ignored inputs: in_valid in IDLE, start in LOAD, both in RUN
    do_clear();
    w0 = we_count;
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("t5_idle_no_we", 32'(we_count - w0), 0);
    start_load(3);
    push(8'h01, 0, 0);
    start = 1'b1; load_len = 4'd1;
    @(negedge clk);
    start = 1'b0;
    push(8'h02, 0, 0);
    chk("t5_addr_after_start", 32'(ram_addr), 1);
    push(8'h03, 0, 1);
    push(8'hFA, 0, 0);
    wait_end("t5_end");
    chk("t5_done", 32'(done), 1);
    w0 = we_count;
    in_valid = 1'b1; start = 1'b1; load_len = 4'd2;
    repeat (3) @(negedge clk);
    in_valid = 1'b0; start = 1'b0;
    chk("t5_run_done", 32'(done), 1);
    chk("t5_run_cpu_clear", 32'(cpu_clear), 0);
    chk("t5_run_no_we", 32'(we_count - w0), 0);

    // clear wins over start
    clear = 1'b1; start = 1'b1; load_len = 4'd3;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    chk("t6_ready", 32'(in_ready), 0);
    chk("t6_busy", 32'(busy), 0);
    @(negedge clk);
    chk("t6_ready_hold", 32'(in_ready), 0);

    // Randomized loads
    for (int it = 0; it < 30; it++) begin
      if (done || ($urandom % 2 == 0)) do_clear();
      len = int'($urandom % 16);
      n = (len == 0) ? DEPTH : len;
      bad = ($urandom % 4 == 0);
      sum = 0;
      start_load(len);
      for (int i = 0; i < n; i++) begin
        d = DW'($urandom);
        sum = (sum + int'(d)) % 256;
        push(d, int'($urandom % 3), ($urandom % 8 == 0));
      end
      d = DW'((256 - sum + (bad ? 1 : 0)) % 256);
      push(d, int'($urandom % 3), 0);
      wait_end("rand_end");
      chk("rand_outcome", 32'(done), 32'(!bad));
    end

    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) chk("final_mem", 32'(tb_mem[i]), 32'(model_mem[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
